// File: rtl/rotary_encoder_bank.sv
// Multi-channel quadrature decoder: n bounded up/down counters with wrap/saturate, load, clear, error flag.
// Latency: one clock from sampled input change to registered value/pulse; no backpressure, accepts every cycle.
module rotary_encoder_bank #(
  parameter int n         = 2,
  parameter int w         = 16,
  parameter int max_value = 9999,
  parameter int div       = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  input  logic [n-1:0]   clr,
  input  logic [n-1:0]   load,
  input  logic [w-1:0]   load_value,
  input  logic [n-1:0]   wrap,
  output logic [n*w-1:0] value,
  output logic [n-1:0]   up_pulse,
  output logic [n-1:0]   down_pulse,
  output logic [n-1:0]   error
);

  localparam logic [w-1:0]        max_v   = w'(max_value);
  localparam logic signed [3:0]   sub_top = 4'(div - 1);
  localparam logic signed [3:0]   sub_bot = -sub_top;

  logic [1:0]        ab_q [n];
  logic signed [3:0] sub  [n];
  logic [w-1:0]      val  [n];

  // Position of a code along the clockwise Gray cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gray_pos(input logic [1:0] code);
    case (code)
      2'b00:   gray_pos = 2'd0;
      2'b10:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  // 1 = clockwise, 3 = counter-clockwise, 2 = both bits changed, 0 = idle.
  function automatic logic [1:0] step_of(input logic [1:0] prev, input logic [1:0] cur);
    step_of = gray_pos(cur) - gray_pos(prev);
  endfunction

  function automatic logic [w-1:0] inc_val(input logic [w-1:0] v, input logic wr);
    if (v >= max_v) inc_val = wr ? '0 : max_v;
    else            inc_val = v + 1'b1;
  endfunction

  function automatic logic [w-1:0] dec_val(input logic [w-1:0] v, input logic wr);
    if (v == '0) dec_val = wr ? max_v : '0;
    else         dec_val = v - 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < n; i++) begin
      // ab_q tracks the inputs even in reset so release never looks like a step.
      ab_q[i]       <= {a[i], b[i]};
      up_pulse[i]   <= 1'b0;
      down_pulse[i] <= 1'b0;
      if (reset) begin
        sub[i]   <= '0;
        val[i]   <= '0;
        error[i] <= 1'b0;
      end else if (clr[i]) begin
        sub[i]   <= '0;
        val[i]   <= '0;
        error[i] <= 1'b0;
      end else if (load[i]) begin
        sub[i] <= '0;
        val[i] <= (load_value > max_v) ? max_v : load_value;
      end else begin
        case (step_of(ab_q[i], {a[i], b[i]}))
          2'd1: begin
            if (sub[i] == sub_top) begin
              sub[i]      <= '0;
              up_pulse[i] <= 1'b1;
              val[i]      <= inc_val(val[i], wrap[i]);
            end else begin
              sub[i] <= sub[i] + 4'sd1;
            end
          end
          2'd3: begin
            if (sub[i] == sub_bot) begin
              sub[i]        <= '0;
              down_pulse[i] <= 1'b1;
              val[i]        <= dec_val(val[i], wrap[i]);
            end else begin
              sub[i] <= sub[i] - 4'sd1;
            end
          end
          2'd2:    error[i] <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < n; g++) begin : g_out
    assign value[g*w +: w] = val[g];
  end

endmodule

// File: tb/tb_rotary_encoder_bank.sv
// Directed bench for rotary_encoder_bank (n=2, w=16, max 9999, div=4).
module tb_rotary_encoder_bank;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  a, b, clr, load, wrap;
  logic [15:0] load_value;
  logic [31:0] value;
  logic [1:0]  up_pulse, down_pulse, error;

  int tests  = 0;
  int failed = 0;

  rotary_encoder_bank #(.n(2), .w(16), .max_value(9999), .div(4)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .clr(clr), .load(load),
    .load_value(load_value), .wrap(wrap), .value(value),
    .up_pulse(up_pulse), .down_pulse(down_pulse), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic [1:0] ab);
    a[0] = ab[1];
    b[0] = ab[0];
  endtask

  task automatic set1(input logic [1:0] ab);
    a[1] = ab[1];
    b[1] = ab[0];
  endtask

  initial begin
    reset = 1'b1; a = '0; b = '0; clr = '0; load = '0; wrap = 2'b11; load_value = '0;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("reset_value", value, 32'd0);
    chk("reset_pulses", {up_pulse, down_pulse}, 32'd0);
    chk("reset_error", error, 32'd0);

    // 1: one clockwise detent on ch0, two cycles per step
    set0(2'b10); tick(2);
    set0(2'b11); tick(2);
    set0(2'b01); tick(2);
    chk("t1_no_early_pulse", up_pulse, 32'd0);
    chk("t1_value_before", value[15:0], 32'd0);
    set0(2'b00); tick(1);
    chk("t1_up_pulse", up_pulse, 32'd1);
    chk("t1_value0", value[15:0], 32'd1);
    chk("t1_value1", value[31:16], 32'd0);
    tick(1);
    chk("t1_pulse_one_cycle", up_pulse, 32'd0);

    // 2: decrement below 0 with wrap, then with saturate
    clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
    set0(2'b01); tick(1); set0(2'b11); tick(1); set0(2'b10); tick(1); set0(2'b00); tick(1);
    chk("t2_wrap_value", value[15:0], 32'd9999);
    chk("t2_wrap_down", down_pulse, 32'd1);
    clr[0] = 1'b1; wrap[0] = 1'b0; tick(1); clr[0] = 1'b0;
    set0(2'b01); tick(1); set0(2'b11); tick(1); set0(2'b10); tick(1); set0(2'b00); tick(1);
    chk("t2_sat_value", value[15:0], 32'd0);
    chk("t2_sat_down", down_pulse, 32'd1);

    // increment at max: saturate holds, wrap rolls to 0
    load_value = 16'd9999; load[0] = 1'b1; tick(1); load[0] = 1'b0;
    set0(2'b10); tick(1); set0(2'b11); tick(1); set0(2'b01); tick(1); set0(2'b00); tick(1);
    chk("t2_sat_max", value[15:0], 32'd9999);
    chk("t2_sat_up", up_pulse, 32'd1);
    wrap[0] = 1'b1;
    set0(2'b10); tick(1); set0(2'b11); tick(1); set0(2'b01); tick(1); set0(2'b00); tick(1);
    chk("t2_wrap_max", value[15:0], 32'd0);

    // 3: load clamps; clr beats load
    load_value = 16'd12000; load[0] = 1'b1; tick(1); load[0] = 1'b0;
    chk("t3_load_clamp", value[15:0], 32'd9999);
    load_value = 16'd5; load[0] = 1'b1; clr[0] = 1'b1; tick(1); load[0] = 1'b0; clr[0] = 1'b0;
    chk("t3_clr_over_load", value[15:0], 32'd0);

    // 4: illegal step on ch1; load keeps error, clr clears it
    load_value = 16'd77; load[1] = 1'b1; tick(1); load[1] = 1'b0;
    set1(2'b11); tick(1);
    chk("t4_error", error, 32'd2);
    chk("t4_value_kept", value[31:16], 32'd77);
    load_value = 16'd20; load[1] = 1'b1; tick(1); load[1] = 1'b0;
    chk("t4_load_keeps_err", error, 32'd2);
    chk("t4_load_value", value[31:16], 32'd20);
    clr[1] = 1'b1; tick(1); clr[1] = 1'b0;
    chk("t4_clr_err", error, 32'd0);
    chk("t4_clr_value", value[31:16], 32'd0);

    // 5: partial detent then reversal unwinds with no output
    load_value = 16'd500; load[0] = 1'b1; tick(1); load[0] = 1'b0;
    begin
      logic [1:0] seq [6];
      logic [3:0] seen;
      seq = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00};
      seen = '0;
      for (int k = 0; k < 6; k++) begin
        set0(seq[k]); tick(1);
        seen = seen | {up_pulse, down_pulse};
      end
      chk("t5_no_pulses", seen, 32'd0);
    end
    chk("t5_value", value[15:0], 32'd500);
    set0(2'b10); tick(1); set0(2'b11); tick(1); set0(2'b01); tick(1);
    chk("t5_sub_zero_3steps", value[15:0], 32'd500);
    set0(2'b00); tick(1);
    chk("t5_sub_zero_detent", value[15:0], 32'd501);

    // 6: reset mid-detent while a=b=1
    set0(2'b10); tick(1); set0(2'b11); tick(1);
    reset = 1'b1; tick(3); reset = 1'b0; tick(1);
    chk("t6_values", value, 32'd0);
    chk("t6_pulses", {up_pulse, down_pulse}, 32'd0);
    set0(2'b01); tick(1); set0(2'b00); tick(1); set0(2'b10); tick(1);
    chk("t6_three_steps", value[15:0], 32'd0);
    set0(2'b11); tick(1);
    chk("t6_detent", value[15:0], 32'd1);
    chk("t6_up", up_pulse, 32'd1);
    tick(2);
    chk("t6_hold", value, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
